// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared constants and types for the framebuffer port arbiter.
//   FB_ADDR_W        : framebuffer word address width (320x240 = 76800 words)
//   FB_DATA_W        : pixel width, 4:4:4 RGB
//   FB_DISP_LATENCY  : display read latency, disp_req -> disp_valid, in cycles
//   FB_STARVE_LIMIT  : writer wait cycles before its starve flag sets
//   acc_e            : which requester owns the BRAM port in a given cycle
// -----------------------------------------------------------------------------
package fb_pkg;

  localparam int FB_ADDR_W       = 17;
  localparam int FB_DATA_W       = 12;
  localparam int FB_DISP_LATENCY = 3;
  localparam int FB_STARVE_LIMIT = 16;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_DISP = 2'd1,
    ACC_WR0  = 2'd2,
    ACC_WR1  = 2'd3
  } acc_e;

  // Width needed to hold the values 0..limit inclusive.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. The grant is combinational; the priority
// pointer moves only when the caller reports a completed transfer (advance).
//   vga_clock : clock, rising edge
//   reset_n   : asynchronous active-low reset (requester 0 preferred first)
//   req[1:0]  : request vector
//   advance   : the current grant completed a transfer this cycle
//   gnt[1:0]  : one-hot grant (all zero when nothing requests)
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       vga_clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // High when requester 1 wins a tie, i.e. requester 0 was served last.
  logic prio_wr1;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_wr1 ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_wr1 <= 1'b0;
    end else if (advance) begin
      prio_wr1 <= gnt[0];
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// -----------------------------------------------------------------------------
// fb_port_arbiter
// Shares one single-port framebuffer BRAM between the display scanout reader
// (absolute priority) and two round-robin writers. One BRAM access per cycle.
//   vga_clock, reset_n            : pixel clock / async active-low reset
//   disp_req, disp_addr           : display read request (one per cycle max)
//   disp_valid, disp_data         : read data, 3 cycles after disp_req
//   wrN_valid/addr/data, wrN_ready: writer N handshake (ready combinational)
//   mem_en/we/addr/wdata, mem_rdata: registered BRAM port, 1-cycle read latency
//   starve[1:0]                   : writer N waited >= STARVE_LIMIT cycles
//   wr_stall_cnt                  : saturating count of cycles any writer stalled
// -----------------------------------------------------------------------------
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter int STARVE_LIMIT = FB_STARVE_LIMIT
) (
  input  logic              vga_clock,
  input  logic              reset_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr0_valid,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  output logic              wr0_ready,
  input  logic              wr1_valid,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr1_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        starve,
  output logic [15:0]       wr_stall_cnt
);

  localparam int                WAIT_W  = cnt_width(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0] LIMIT_W = WAIT_W'(STARVE_LIMIT);

  function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
    return (v >= LIMIT_W) ? LIMIT_W : v + WAIT_W'(1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  acc_e             acc_sel;
  logic [1:0]       wr_req;
  logic [1:0]       rr_gnt;
  logic [1:0]       xfer;
  logic             any_stall;
  logic             vld_p0;
  logic             vld_p1;
  logic             vld_p2;
  logic [WAIT_W-1:0] wait_cnt0;
  logic [WAIT_W-1:0] wait_cnt1;

  assign wr_req = {wr1_valid, wr0_valid};

  rr_arb2 u_rr_arb2 (
    .vga_clock (vga_clock),
    .reset_n   (reset_n),
    .req       (wr_req),
    .advance   (|xfer),
    .gnt       (rr_gnt)
  );

  // The display steals the port outright; the round-robin grant is only
  // honoured (and the pointer only moves) on cycles without a display read.
  always_comb begin
    acc_sel = ACC_IDLE;
    if (!reset_n) begin
      acc_sel = ACC_IDLE;
    end else if (disp_req) begin
      acc_sel = ACC_DISP;
    end else if (rr_gnt[0]) begin
      acc_sel = ACC_WR0;
    end else if (rr_gnt[1]) begin
      acc_sel = ACC_WR1;
    end
  end

  assign wr0_ready = (acc_sel == ACC_WR0);
  assign wr1_ready = (acc_sel == ACC_WR1);
  assign xfer      = {wr1_valid & wr1_ready, wr0_valid & wr0_ready};
  assign any_stall = (wr0_valid & ~wr0_ready) | (wr1_valid & ~wr1_ready);

  // ---- stage p0: access issued on the BRAM pins, read tracked in vld_p0 ----
  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      vld_p0    <= 1'b0;
    end else begin
      mem_en <= (acc_sel != ACC_IDLE);
      mem_we <= (acc_sel == ACC_WR0) || (acc_sel == ACC_WR1);
      vld_p0 <= (acc_sel == ACC_DISP);
      unique case (acc_sel)
        ACC_DISP: mem_addr <= disp_addr;
        ACC_WR0: begin
          mem_addr  <= wr0_addr;
          mem_wdata <= wr0_data;
        end
        ACC_WR1: begin
          mem_addr  <= wr1_addr;
          mem_wdata <= wr1_data;
        end
        default: ;
      endcase
    end
  end

  // ---- stage p1: BRAM drives mem_rdata for the read tracked in vld_p1 ----
  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
    end
  end

  // ---- stage p2: read data captured and presented to the display ----
  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p2    <= 1'b0;
      disp_data <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        disp_data <= mem_rdata;
      end
    end
  end

  assign disp_valid = vld_p2;

  // Wait counters restart whenever the writer drops valid, so an abandoned
  // request leaves nothing behind.
  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt0    <= '0;
      wait_cnt1    <= '0;
      wr_stall_cnt <= '0;
    end else begin
      if (!wr0_valid || xfer[0]) begin
        wait_cnt0 <= '0;
      end else begin
        wait_cnt0 <= sat_inc_wait(wait_cnt0);
      end
      if (!wr1_valid || xfer[1]) begin
        wait_cnt1 <= '0;
      end else begin
        wait_cnt1 <= sat_inc_wait(wait_cnt1);
      end
      if (any_stall) begin
        wr_stall_cnt <= sat_inc16(wr_stall_cnt);
      end
    end
  end

  assign starve = {wait_cnt1 == LIMIT_W, wait_cnt0 == LIMIT_W};

endmodule

// File: tb/tb_fb_port_arbiter.sv
module tb_fb_port_arbiter;

  localparam int AW  = 17;
  localparam int DW  = 12;
  localparam int LIM = 16;

  logic          vga_clock = 1'b0;
  logic          reset_n;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          wr0_valid, wr1_valid;
  logic [AW-1:0] wr0_addr, wr1_addr;
  logic [DW-1:0] wr0_data, wr1_data;
  logic          wr0_ready, wr1_ready;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    starve;
  logic [15:0]   wr_stall_cnt;

  always #20 vga_clock = ~vga_clock;

  fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .vga_clock    (vga_clock),
    .reset_n      (reset_n),
    .disp_req     (disp_req),
    .disp_addr    (disp_addr),
    .disp_valid   (disp_valid),
    .disp_data    (disp_data),
    .wr0_valid    (wr0_valid),
    .wr0_addr     (wr0_addr),
    .wr0_data     (wr0_data),
    .wr0_ready    (wr0_ready),
    .wr1_valid    (wr1_valid),
    .wr1_addr     (wr1_addr),
    .wr1_data     (wr1_data),
    .wr1_ready    (wr1_ready),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .starve       (starve),
    .wr_stall_cnt (wr_stall_cnt)
  );

  // Behavioural BRAM: background pattern plus written words.
  logic [DW-1:0] bram_mem [int];
  logic [DW-1:0] shadow   [int];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a[11:0] ^ 12'h5A5;
  endfunction

  always @(posedge vga_clock) begin
    if (mem_en) begin
      if (mem_we) bram_mem[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= bram_mem.exists(int'(mem_addr)) ? bram_mem[int'(mem_addr)] : pat(mem_addr);
    end
  end

  typedef struct {
    int            due;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_exp_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_exp_t;

  mem_exp_t mq[$];
  rd_exp_t  rq[$];

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  logic          m_ptr;
  int            m_wc0, m_wc1, m_stall;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_wdata;
  logic [1:0]    obs_rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : pat(a);
  endfunction

  task automatic model_reset();
    m_ptr = 1'b0; m_wc0 = 0; m_wc1 = 0; m_stall = 0;
    m_last_addr = '0; m_last_wdata = '0;
    mq.delete(); rq.delete();
  endtask

  // Compare registered outputs (valid since the last rising edge) with the scoreboard.
  task automatic monitor();
    mem_exp_t me;
    rd_exp_t  re;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      me = mq.pop_front();
      chk("mem_en", mem_en, 1);
      chk("mem_we", mem_we, me.we);
      chk("mem_addr", mem_addr, me.addr);
      m_last_addr = me.addr;
      if (me.we) begin
        chk("mem_wdata", mem_wdata, me.data);
        m_last_wdata = me.data;
      end else begin
        chk("mem_wdata_hold", mem_wdata, m_last_wdata);
      end
    end else begin
      chk("mem_en_idle", mem_en, 0);
      chk("mem_we_idle", mem_we, 0);
      chk("mem_addr_hold", mem_addr, m_last_addr);
      chk("mem_wdata_hold", mem_wdata, m_last_wdata);
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      re = rq.pop_front();
      chk("disp_valid", disp_valid, 1);
      chk("disp_data", disp_data, re.data);
    end else begin
      chk("disp_valid_idle", disp_valid, 0);
    end
    chk("starve", starve, {m_wc1 == LIM, m_wc0 == LIM});
    chk("wr_stall_cnt", wr_stall_cnt, m_stall);
  endtask

  // One clock cycle: called and returns at a falling edge.
  task automatic cycle(input logic dr, input logic [AW-1:0] da,
                       input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    logic [1:0] g;
    monitor();
    disp_req = dr; disp_addr = da;
    wr0_valid = v0; wr0_addr = a0; wr0_data = d0;
    wr1_valid = v1; wr1_addr = a1; wr1_data = d1;
    #1;
    g = 2'b00;
    if (!dr) begin
      if (v0 && v1) g = m_ptr ? 2'b10 : 2'b01;
      else g = {v1, v0};
    end
    obs_rdy = {wr1_ready, wr0_ready};
    chk("wr0_ready", wr0_ready, g[0]);
    chk("wr1_ready", wr1_ready, g[1]);
    if (dr) begin
      mq.push_back('{cyc + 1, 1'b0, da, '0});
      rq.push_back('{cyc + 3, shadow_rd(da)});
    end else if (g[0]) begin
      mq.push_back('{cyc + 1, 1'b1, a0, d0});
      shadow[int'(a0)] = d0;
      m_ptr = 1'b1;
    end else if (g[1]) begin
      mq.push_back('{cyc + 1, 1'b1, a1, d1});
      shadow[int'(a1)] = d1;
      m_ptr = 1'b0;
    end
    if (((v0 && !g[0]) || (v1 && !g[1])) && m_stall < 16'hFFFF) m_stall++;
    if (!v0 || g[0]) m_wc0 = 0; else if (m_wc0 < LIM) m_wc0++;
    if (!v1 || g[1]) m_wc1 = 0; else if (m_wc1 < LIM) m_wc1++;
    @(posedge vga_clock);
    @(negedge vga_clock);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_disp_valid"}, disp_valid, 0);
    chk({tag, "_disp_data"}, disp_data, 0);
    chk({tag, "_starve"}, starve, 0);
    chk({tag, "_stall_cnt"}, wr_stall_cnt, 0);
    chk({tag, "_ready"}, {wr1_ready, wr0_ready}, 0);
  endtask

  // Entered at a falling edge; requests are held high to show ready stays low.
  task automatic do_reset();
    reset_n = 1'b0;
    disp_req = 1'b1; wr0_valid = 1'b1; wr1_valid = 1'b1;
    #1;
    check_reset_outputs("rst_now");
    @(posedge vga_clock);
    @(negedge vga_clock);
    check_reset_outputs("rst_hold");
    disp_req = 1'b0; wr0_valid = 1'b0; wr1_valid = 1'b0;
    reset_n = 1'b1;
    model_reset();
  endtask

  logic [7:0] seq;

  initial begin
    reset_n = 1'b0;
    disp_req = 0; disp_addr = '0;
    wr0_valid = 0; wr0_addr = '0; wr0_data = '0;
    wr1_valid = 0; wr1_addr = '0; wr1_data = '0;
    bram_mem[16] = 12'hABC;
    shadow[16]   = 12'hABC;
    @(negedge vga_clock);
    do_reset();

    // Single display read at cycle 5, BRAM holding 0xABC.
    idle(5);
    cycle(1, 17'h00010, 0, '0, '0, 0, '0, '0);
    chk("rd_mem_addr", mem_addr, 17'h00010);
    idle(2);
    chk("rd_valid_t3", disp_valid, 1);
    chk("rd_data_t3", disp_data, 12'hABC);
    idle(1);
    chk("rd_valid_t4", disp_valid, 0);
    idle(2);

    // Both writers pending: alternate starting with wr0.
    do_reset();
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, '0, 1, AW'(17'h100 + i), DW'(12'h100 + i), 1, AW'(17'h200 + i), DW'(12'h200 + i));
      seq = {seq[5:0], obs_rdy};
    end
    chk("rr_seq", seq, 8'b01_10_01_10);
    idle(2);

    // Display blocks wr0 for 3 cycles, then wr0 goes through.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, AW'(17'h40 + i), 1, 17'h300, 12'h333, 0, '0, '0);
    chk("stall3", wr_stall_cnt, 16'd3);
    cycle(0, '0, 1, 17'h300, 12'h333, 0, '0, '0);
    chk("wr0_after_disp", obs_rdy, 2'b01);
    idle(4);

    // Starvation of wr1 under continuous display reads.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(1, AW'(i), 0, '0, '0, 1, 17'h500, 12'h555);
      if (i == 14) chk("starve_pre", starve, 2'b00);
      if (i == 15) chk("starve_on", starve, 2'b10);
    end
    chk("starve_held", starve, 2'b10);
    cycle(0, '0, 0, '0, '0, 1, 17'h500, 12'h555);
    chk("wr1_resume", obs_rdy, 2'b10);
    idle(1);
    chk("starve_clr", starve, 2'b00);
    idle(3);

    // Mixed random traffic, including writers that give up.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 9) < 3), AW'($urandom_range(0, 255)),
            $urandom_range(0, 1) == 1, AW'($urandom_range(0, 255)), DW'($urandom),
            $urandom_range(0, 1) == 1, AW'($urandom_range(0, 255)), DW'($urandom));
    end
    idle(4);

    // Reset with two reads in flight: they must never appear.
    cycle(1, 17'h20, 0, '0, '0, 0, '0, '0);
    cycle(1, 17'h21, 0, '0, '0, 0, '0, '0);
    do_reset();
    idle(6);

    // Long stall: stall counter saturates without wrapping.
    do_reset();
    for (int i = 0; i < 65540; i++) cycle(1, '0, 1, 17'h600, 12'h666, 0, '0, '0);
    chk("stall_sat", wr_stall_cnt, 16'hFFFF);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 17, framebuffer word address width (320x240 = 76800 words); DATA_W, default 12, pixel width (4:4:4 RGB); STARVE_LIMIT, default 16, writer wait cycles before the starve flag sets.
REQ-002 Ports SHALL be (name  direction  width  meaning):
 vga_clock  in  1  sole clock, 25 MHz pixel clock, rising edge
 reset_n  in  1  asynchronous, active-low reset
 disp_req  in  1  display scanout read request, one per cycle max
 disp_addr  in  ADDR_W  display read address
 disp_valid  out  1  read data valid strobe
 disp_data  out  DATA_W  read pixel data
 wr0_valid / wr1_valid  in  1  writer N has a write pending
 wr0_addr / wr1_addr  in  ADDR_W  writer N address
 wr0_data / wr1_data  in  DATA_W  writer N data
 wr0_ready / wr1_ready  out  1  writer N write accepted this cycle
 mem_en  out  1  BRAM port enable
 mem_we  out  1  BRAM write enable
 mem_addr  out  ADDR_W  BRAM address
 mem_wdata  out  DATA_W  BRAM write data
 mem_rdata  in  DATA_W  BRAM read data, 1-cycle latency after mem_en
 starve  out  2  bit N set while writer N has waited >= STARVE_LIMIT cycles
 wr_stall_cnt  out  16  saturating count of cycles with a writer valid but not ready

Function
REQ-003 Arbitration SHALL be evaluated every cycle over a single-port BRAM; at most one access is issued per cycle.
REQ-004 disp_req SHALL have absolute priority; a display read is never delayed or dropped.
REQ-005 If disp_req is low, the writers SHALL be arbitrated round-robin: when both are valid, the grant goes to the writer not granted most recently; a lone valid writer is granted immediately.
REQ-006 wrN_ready SHALL be combinational, high only in the grant cycle; the transfer occurs when wrN_valid and wrN_ready are both high.
REQ-007 The round-robin pointer SHALL update only on a completed writer transfer, never on display cycles.
REQ-008 mem_en, mem_we, mem_addr and mem_wdata SHALL be registered: an access granted in cycle t appears on the BRAM pins in cycle t+1.
REQ-009 Display read latency SHALL be exactly 3 cycles:
 - disp_req in cycle t
 - mem_en=1 and mem_we=0 in t+1
 - mem_rdata in t+2
 - disp_valid=1 and disp_data registered in t+3
REQ-010 A 3-stage valid shift register SHALL track in-flight reads; back-to-back disp_req SHALL produce back-to-back disp_valid in order.
REQ-011 With no grant, mem_en SHALL be 0, mem_we SHALL be 0, and mem_addr/mem_wdata SHALL hold their last values.
REQ-012 A per-writer wait counter SHALL:
 - increment each cycle wrN_valid is high and wrN_ready is low, saturating at STARVE_LIMIT
 - clear on transfer or when wrN_valid is low
 - drive starve[N] high while it equals STARVE_LIMIT
REQ-013 wr_stall_cnt SHALL add 1 per cycle in which any writer is stalled (not per writer) and saturate at 16'hFFFF.
REQ-014 Writer valid dropping without a transfer SHALL be legal; no state SHALL be retained for it.
REQ-015 With disp_req held high continuously, writers SHALL stall indefinitely with no transfer and starve asserted; writers SHALL resume round-robin on the first cycle disp_req is low.

Reset
REQ-016 Asserting reset_n low SHALL immediately clear all of the following: mem_en, mem_we, mem_addr, mem_wdata, disp_valid, disp_data, starve, wr_stall_cnt, wait counters, the valid shift register, and the round-robin pointer (wr0 preferred first).
REQ-017 Reset mid-operation SHALL discard in-flight reads; no disp_valid SHALL appear after reset_n deasserts until a new disp_req.
REQ-018 wrN_ready SHALL be low while reset_n is low.

Structure
REQ-019 ADDR_W/DATA_W defaults, the display latency constant (3), and STARVE_LIMIT SHALL live in shared package fb_pkg.
REQ-020 The two-requester round-robin SHALL be a sub-module rr_arb2 (inputs req[1:0] and advance; output one-hot gnt[1:0]).

Verification
REQ-021 disp_req=1 with disp_addr=0x00010 in cycle 5 and BRAM returning 0xABC -> mem_en=1, we=0, addr=0x00010 in cycle 6; disp_valid=1 with disp_data=0xABC in cycle 8 only.
REQ-022 wr0_valid and wr1_valid held high for 4 cycles, disp_req=0, after reset -> grants wr0, wr1, wr0, wr1; mem_we=1 one cycle after each grant with the matching addr/data.
REQ-023 disp_req and wr0_valid both high for 3 cycles -> wr0_ready stays 0, three reads issued, wr_stall_cnt=3, wr0 granted on the 4th cycle when disp_req drops.
REQ-024 disp_req high for 20 cycles with wr1_valid high -> starve[1] rises after 16 stalled cycles; starve[1] clears the cycle after the wr1 transfer.
REQ-025 reset_n pulsed low one cycle after two back-to-back disp_req -> no disp_valid afterwards; all outputs read 0 during reset.
REQ-026 wr_stall_cnt preloaded near saturation via a long 65540-cycle stall -> value holds at 0xFFFF with no wrap.
